// File: rtl/memory_stage.sv
// Memory stage: captures one execute result, performs at most one aligned
// doubleword access, and holds the write-back bundle until it is consumed.
module memory_stage #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] ALUResult,
  input  logic [63:0] WriteData,
  input  logic [4:0]  RdIn,
  input  logic        MemRead,
  input  logic        MemtoReg,
  input  logic        MemWrite,
  input  logic        RegWrite,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] ReadData,
  output logic [63:0] ALUResultOut,
  output logic [4:0]  RdOut,
  output logic        MemtoRegOut,
  output logic        RegWriteOut,
  output logic        MisalignErr,
  output logic [31:0] LoadCount,
  output logic [31:0] StoreCount
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [63:0] mem_q [DEPTH];
  logic [63:0] alu_q, wdata_q, rdata_q;
  logic [4:0]  rd_q;
  logic        mr_q, mw_q, m2r_q, rw_q, mis_q;
  logic [31:0] ld_cnt_q, st_cnt_q;

  logic          is_mem_in, misalign_in, accept;
  logic [AW-1:0] idx;

  assign is_mem_in   = MemRead | MemWrite;
  assign misalign_in = is_mem_in && (ALUResult[2:0] != 3'b000);
  assign accept      = (state_q == IDLE) && in_valid;
  // Upper address bits are dropped so addresses wrap modulo DEPTH*8.
  assign idx         = alu_q[3 +: AW];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = (is_mem_in && !misalign_in) ? ACCESS : RESP;
      ACCESS:  state_d = RESP;
      RESP:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_q     <= '0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      m2r_q    <= 1'b0;
      rw_q     <= 1'b0;
      mis_q    <= 1'b0;
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (accept) begin
        alu_q   <= ALUResult;
        wdata_q <= WriteData;
        rdata_q <= '0;
        rd_q    <= RdIn;
        mr_q    <= MemRead;
        mw_q    <= MemWrite;
        m2r_q   <= MemtoReg;
        // A faulting access must never reach the register file.
        rw_q    <= RegWrite & ~misalign_in;
        mis_q   <= misalign_in;
      end
      if (state_q == ACCESS) begin
        // Read samples the old word, so a combined op returns pre-store data.
        if (mr_q) begin
          rdata_q  <= mem_q[idx];
          ld_cnt_q <= ld_cnt_q + 32'd1;
        end
        if (mw_q) begin
          mem_q[idx] <= wdata_q;
          st_cnt_q   <= st_cnt_q + 32'd1;
        end
      end
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == RESP);
  assign ReadData     = rdata_q;
  assign ALUResultOut = alu_q;
  assign RdOut        = rd_q;
  assign MemtoRegOut  = m2r_q;
  assign RegWriteOut  = rw_q;
  assign MisalignErr  = mis_q;
  assign LoadCount    = ld_cnt_q;
  assign StoreCount   = st_cnt_q;

endmodule
